// File: rtl/intra_recon_pipe_if.sv
// Residue-in / reconstructed-row-out handshake bundle for intra_recon_pipe.
// master = residue producer and row consumer; slave = the reconstruction pipe.
interface intra_recon_pipe_if #(
    parameter int BLK   = 4,
    parameter int RES_W = 9
);
    logic                 res_valid;
    logic                 res_ready;
    logic [BLK*RES_W-1:0] res_row;
    logic                 out_valid;
    logic                 out_ready;
    logic [BLK*8-1:0]     out_row;
    logic                 out_last;

    modport master (output res_valid, res_row, out_ready,
                    input  res_ready, out_valid, out_row, out_last);
    modport slave  (input  res_valid, res_row, out_ready,
                    output res_ready, out_valid, out_row, out_last);
endinterface

// File: rtl/intra_recon_pipe.sv
// Intra predictor + residue reconstruction for one BLKxBLK block, one row per handshake.
// Latency: one PRED cycle after start, then each accepted residue row appears registered next cycle.
module intra_recon_pipe #(
    parameter int BLK   = 4,
    parameter int RES_W = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                top_avail,
    input  logic                left_avail,
    input  logic [BLK*8-1:0]    top_pix,
    input  logic [BLK*8-1:0]    left_pix,
    intra_recon_pipe_if.slave   rio,
    output logic                busy,
    output logic                done,
    output logic [BLK*8-1:0]    col_out
);
    localparam int RW = $clog2(BLK);
    localparam int SW = 14;
    localparam int XW = RES_W + 2;

    typedef enum logic [1:0] {IDLE, PRED, STREAM, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]       mode_q;
    logic             top_av_q, left_av_q;
    logic [BLK*8-1:0] top_q, left_q;
    logic [1:0]       pmode, pmode_nxt;   // 0 vertical, 1 horizontal, 2 DC
    logic [7:0]       dc_q, dc_nxt;
    logic [RW-1:0]    r;
    logic [BLK*8-1:0] row_q, col_q, recon;
    logic             ov_q, last_q, res_hs;
    logic [SW-1:0]    sum_top, sum_left;
    logic [7:0]       pred_c [BLK];
    logic signed [XW-1:0] sum_c [BLK];

    assign rio.res_ready = (state == STREAM) && enable && (!ov_q || rio.out_ready);
    assign res_hs        = rio.res_valid && rio.res_ready;
    assign rio.out_valid = ov_q;
    assign rio.out_row   = row_q;
    assign rio.out_last  = last_q;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign col_out       = col_q;

    always_comb begin
        sum_top  = '0;
        sum_left = '0;
        for (int i = 0; i < BLK; i++) begin
            sum_top  = sum_top  + SW'(top_q[8*i +: 8]);
            sum_left = sum_left + SW'(left_q[8*i +: 8]);
        end
        if (top_av_q && left_av_q)
            dc_nxt = 8'((sum_top + sum_left + SW'(BLK)) >> $clog2(2*BLK));
        else if (top_av_q)
            dc_nxt = 8'((sum_top + SW'(BLK/2)) >> $clog2(BLK));
        else if (left_av_q)
            dc_nxt = 8'((sum_left + SW'(BLK/2)) >> $clog2(BLK));
        else
            dc_nxt = 8'd128;
        case (mode_q)
            2'd0:    pmode_nxt = top_av_q  ? 2'd0 : 2'd2;
            2'd1:    pmode_nxt = left_av_q ? 2'd1 : 2'd2;
            default: pmode_nxt = 2'd2;
        endcase
    end

    // Signed sum is wide enough for 255 + max positive residue and for the most negative residue.
    always_comb begin
        recon = '0;
        for (int c = 0; c < BLK; c++) begin
            case (pmode)
                2'd0:    pred_c[c] = top_q[8*c +: 8];
                2'd1:    pred_c[c] = left_q[8*r +: 8];
                default: pred_c[c] = dc_q;
            endcase
            sum_c[c] = $signed({{(XW-8){1'b0}}, pred_c[c]})
                     + $signed({{2{rio.res_row[RES_W*c + RES_W-1]}}, rio.res_row[RES_W*c +: RES_W]});
            if (sum_c[c][XW-1])
                recon[8*c +: 8] = 8'd0;
            else if (sum_c[c][XW-2:8] != '0)
                recon[8*c +: 8] = 8'd255;
            else
                recon[8*c +: 8] = sum_c[c][7:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && start) state_nxt = PRED;
            PRED:    if (enable) state_nxt = STREAM;
            STREAM:  if (res_hs && r == RW'(BLK-1)) state_nxt = DONE;
            DONE:    if (enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            r      <= '0;
            ov_q   <= 1'b0;
            row_q  <= '0;
            last_q <= 1'b0;
            col_q  <= '0;
        end else if (enable) begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                mode_q    <= mode;
                top_av_q  <= top_avail;
                left_av_q <= left_avail;
                top_q     <= top_pix;
                left_q    <= left_pix;
            end
            if (state == PRED) begin
                pmode <= pmode_nxt;
                dc_q  <= dc_nxt;
                r     <= '0;
            end
            if (res_hs) begin
                row_q           <= recon;
                ov_q            <= 1'b1;
                last_q          <= (r == RW'(BLK-1));
                col_q[8*r +: 8] <= recon[8*(BLK-1) +: 8];
                r               <= r + 1'b1;
            end else if (ov_q && rio.out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_intra_recon_pipe.sv
// Randomised bench for intra_recon_pipe with a row-level reference model and scoreboard.
module tb_intra_recon_pipe;
    localparam int BLK   = 4;
    localparam int RES_W = 9;

    logic        clk = 1'b0;
    logic        reset, enable, start, top_avail, left_avail, busy, done;
    logic [1:0]  mode;
    logic [31:0] top_pix, left_pix, col_out;

    intra_recon_pipe_if #(.BLK(BLK), .RES_W(RES_W)) rio ();

    intra_recon_pipe #(.BLK(BLK), .RES_W(RES_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode),
        .top_avail(top_avail), .left_avail(left_avail),
        .top_pix(top_pix), .left_pix(left_pix), .rio(rio),
        .busy(busy), .done(done), .col_out(col_out)
    );

    always #5 clk = ~clk;

    int          vec = 0, err = 0, done_seen = 0, ord_mode = 2;
    logic [32:0] sb[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int dc_of(input bit tav, input bit lav, input logic [31:0] top, input logic [31:0] left);
        int st = 0, sl = 0;
        for (int i = 0; i < 4; i++) begin
            st += int'(top[8*i +: 8]);
            sl += int'(left[8*i +: 8]);
        end
        if (tav && lav) return (st + sl + 4) / 8;
        if (tav) return (st + 2) / 4;
        if (lav) return (sl + 2) / 4;
        return 128;
    endfunction

    function automatic logic [31:0] model_row(input int m, input bit tav, input bit lav,
                                              input logic [31:0] top, input logic [31:0] left,
                                              input int r, input logic [35:0] res);
        logic [31:0]       row;
        logic signed [8:0] rv;
        int                p, v;
        row = '0;
        for (int c = 0; c < 4; c++) begin
            if (m == 0 && tav)      p = int'(top[8*c +: 8]);
            else if (m == 1 && lav) p = int'(left[8*r +: 8]);
            else                    p = dc_of(tav, lav, top, left);
            rv = res[9*c +: 9];
            v  = p + int'(rv);
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            row[8*c +: 8] = 8'(v);
        end
        return row;
    endfunction

    always @(posedge clk) begin
        #2;
        case (ord_mode)
            0:       rio.out_ready = ($urandom_range(0, 2) != 0);
            1:       rio.out_ready = 1'b1;
            default: rio.out_ready = 1'b0;
        endcase
    end

    // Row scoreboard: every presented row must match the head; pop on an output handshake.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (!reset && rio.out_valid) begin
            if (sb.size() == 0) begin
                vec++;
                err++;
                $display("FAIL out_spurious: got %0h expected no row", rio.out_row);
            end else begin
                check("out_row_last", {31'b0, rio.out_last, rio.out_row}, {31'b0, sb[0]});
                if (rio.out_ready && enable) void'(sb.pop_front());
            end
        end
    end

    task automatic run_block(input int m, input bit tav, input bit lav,
                             input logic [31:0] top, input logic [31:0] left,
                             input logic [35:0] res [4], input bit en_rand,
                             input bit hold, input bit spur, input int abort_at);
        logic [31:0] exp_col, row;
        bit          acc, got;
        int          d0;
        exp_col = '0;
        @(negedge clk);
        check("busy_idle", {63'b0, busy}, 64'd0);
        @(posedge clk); #1;
        mode = 2'(m); top_avail = tav; left_avail = lav; top_pix = top; left_pix = left;
        start = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            row = model_row(m, tav, lav, top, left, r, res[r]);
            sb.push_back({(r == 3), row});
            exp_col[8*r +: 8] = row[31:24];
        end
        for (int r = 0; r < 4; r++) begin
            rio.res_row = res[r];
            if (r == abort_at) begin
                rio.res_valid = 1'b1; reset = 1'b1; enable = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0; enable = 1'b1; rio.res_valid = 1'b0;
                sb.delete();
                @(negedge clk);
                check("abort_busy", {63'b0, busy}, 64'd0);
                check("abort_out_valid", {63'b0, rio.out_valid}, 64'd0);
                check("abort_done", {63'b0, done}, 64'd0);
                check("abort_res_ready", {63'b0, rio.res_ready}, 64'd0);
                check("abort_col_out", {32'b0, col_out}, 64'd0);
                d0 = done_seen;
                repeat (4) @(posedge clk);
                #1;
                check("abort_no_done", 64'(done_seen), 64'(d0));
                return;
            end
            if (en_rand) begin
                rio.res_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    enable = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
            rio.res_valid = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 200 && !acc; k++) begin
                enable = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (spur && r == 1 && k == 0) begin
                    start = 1'b1; mode = ~2'(m); top_pix = $urandom;
                end
                @(negedge clk);
                acc = rio.res_ready;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (!acc) begin
                vec++; err++;
                $display("FAIL res_accept_timeout: got no acceptance expected row %0d", r);
                return;
            end
            if (hold && r == 0) begin
                ord_mode = 2;
                rio.res_row = res[1];
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("hold_res_ready", {63'b0, rio.res_ready}, 64'd0);
                    check("hold_out_valid", {63'b0, rio.out_valid}, 64'd1);
                    @(posedge clk); #1;
                end
                ord_mode = 1;
            end
        end
        rio.res_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            enable = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("col_out", {32'b0, col_out}, {32'b0, exp_col});
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            vec++; err++;
            $display("FAIL done_timeout: got no done expected one pulse");
        end
        enable = 1'b1;
        @(negedge clk);
        if (!en_rand) check("done_one_cycle", {63'b0, done}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_done", {62'b0, busy, done}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        logic [35:0] res [4];
        logic [31:0] top, left;
        reset = 1'b1; enable = 1'b0; start = 1'b1; mode = 2'd0;
        top_avail = 1'b0; left_avail = 1'b0; top_pix = '0; left_pix = '0;
        rio.res_valid = 1'b0; rio.res_row = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; enable = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_out_valid", {63'b0, rio.out_valid}, 64'd0);
        check("rst_out_last", {63'b0, rio.out_last}, 64'd0);
        check("rst_out_row", {32'b0, rio.out_row}, 64'd0);
        check("rst_res_ready", {63'b0, rio.res_ready}, 64'd0);
        check("rst_col_out", {32'b0, col_out}, 64'd0);
        @(posedge clk); #1;

        top = {8'd40, 8'd30, 8'd20, 8'd10};
        check("pin_dc_both", 64'(dc_of(1, 1, {4{8'd100}}, {4{8'd104}})), 64'd102);
        check("pin_dc_top_only", 64'(dc_of(1, 0, {8'd4, 8'd3, 8'd2, 8'd1}, 32'hFFFFFFFF)), 64'd3);
        check("pin_dc_none", 64'(dc_of(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'd128);
        check("pin_vertical_clip", {32'b0, model_row(0, 1, 1, top, 32'h0, 0, {9'd5, 9'd0, 9'h1CE, 9'h0FA})},
              64'h2D1E00FF);
        check("pin_dc_row", {32'b0, model_row(3, 1, 1, {4{8'd100}}, {4{8'd104}}, 2, 36'd0)},
              {32'b0, {4{8'd102}}});

        ord_mode = 1;
        for (int r = 0; r < 4; r++) res[r] = '0;
        run_block(2, 1, 1, {4{8'd100}}, {4{8'd104}}, res, 0, 0, 0, -1);

        res[0] = {9'd5, 9'd0, 9'h1CE, 9'h0FA};
        for (int r = 1; r < 4; r++) res[r] = {$urandom, 4'(($urandom))};
        run_block(0, 1, 1, top, $urandom, res, 0, 0, 0, -1);

        for (int r = 0; r < 4; r++) res[r] = '0;
        run_block(1, 1, 0, {8'd4, 8'd3, 8'd2, 8'd1}, $urandom, res, 0, 1, 0, -1);

        for (int r = 0; r < 4; r++) res[r] = {$urandom, 4'(($urandom))};
        run_block(0, 1, 1, $urandom, $urandom, res, 0, 0, 1, 2);
        run_block(1, 1, 1, $urandom, $urandom, res, 0, 0, 0, -1);

        ord_mode = 0;
        for (int b = 0; b < 40; b++) begin
            for (int r = 0; r < 4; r++) res[r] = {$urandom, 4'(($urandom))};
            top  = $urandom;
            left = $urandom;
            if (b % 5 == 0) top = {4{8'(($urandom_range(240, 255)))}};
            run_block(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), top, left, res,
                      1, 0, 1'($urandom), -1);
        end

        ord_mode = 1;
        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/intra_recon_pipe.md
INTRA_RECON_PIPE -- requirements
Module: intra_recon_pipe

Interface
REQ-001 SHALL have parameter BLK, default 4, giving the square block edge in pixels; legal values are 4, 8 and 16.
REQ-002 SHALL have parameter RES_W, default 9, giving the signed residue width per pixel.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  global advance; when low, all state and outputs hold.
REQ-006 start  input  1  one-cycle block start, sampled only in IDLE.
REQ-007 mode  input  2  0=vertical, 1=horizontal, 2=DC, 3=reserved (treated as DC).
REQ-008 top_avail, left_avail  input  1 each  neighbour availability flags.
REQ-009 top_pix, left_pix  input  BLK*8 each  neighbour pixels; pixel i is at bits [8i+7:8i].
REQ-010 res_valid, res_ready  input, output  1 each  residue row handshake.
REQ-011 res_row  input  BLK*RES_W  signed residue row, packed the same way as the pixel buses.
REQ-012 out_valid, out_ready  output, input  1 each  reconstructed row handshake.
REQ-013 out_row  output  BLK*8  reconstructed row.
REQ-014 out_last  output  1  high with the final row, BLK-1.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 col_out  output  BLK*8  right column of the block just finished, for the next block's left neighbours.

Function
REQ-018 FSM states: IDLE, PRED, STREAM, DONE; a transition occurs only on a cycle where enable=1.
REQ-019 IDLE: on start=1, the block latches mode, both avail flags, top_pix and left_pix, then moves to PRED; otherwise it stays in IDLE.
REQ-020 start is ignored in every state other than IDLE.
REQ-021 Mode fallback rules:
- vertical with top_avail=0 uses DC;
- horizontal with left_avail=0 uses DC.
REQ-022 DC value, with S = sum of available neighbours:
- both available: DC = (S_top + S_left + BLK) >> log2(2*BLK);
- one side available: DC = (S + BLK/2) >> log2(BLK);
- none available: DC = 128.
REQ-023 PRED lasts exactly one cycle, computes the predictor, then moves to STREAM with row counter r=0.
REQ-024 Predictor for pixel (r,c):
- vertical: top[c];
- horizontal: left[r];
- DC: the value from REQ-022.
REQ-025 res_ready = (state==STREAM) && enable && (!out_valid || out_ready).
REQ-026 Reconstruction: on a residue handshake, out_row[c] = clip(pred(r,c) + res[c], 0, 255), computed at RES_W+2 signed width.
REQ-027 Each accepted row is registered: out_valid rises on the following cycle, and r increments.
REQ-028 While out_valid=1 and out_ready=0, out_row, out_last and out_valid hold stable.
REQ-029 out_last = 1 exactly when the presented row is row BLK-1.
REQ-030 Pixel BLK-1 of every accepted row is captured into col_out[r].
REQ-031 After the handshake of the last row, the FSM enters DONE; done=1 for that one cycle, col_out is stable, then the FSM returns to IDLE.
REQ-032 A new start is accepted no earlier than the IDLE cycle that follows DONE.

Reset
REQ-033 While reset=1, on the clock edge the FSM goes to IDLE, r=0, and out_valid, out_row, out_last, done, busy, res_ready and col_out all become 0.
REQ-034 Reset overrides enable and start.
REQ-035 A reset during PRED or STREAM aborts the block: the partial row is discarded and no done is produced.

Verification
REQ-036 BLK=4, DC, both available, top=100 x4, left=104 x4, residue 0 -> DC=(400+416+4)>>3=102; four rows of 102; out_last on row 3; then done.
REQ-037 Vertical, top={10,20,30,40}, row 0 residue={250,-50,0,5} -> out_row={255,0,30,45}.
REQ-038 Horizontal, left_avail=0, top_avail=1, top={1,2,3,4} -> DC=(10+2)>>2=3 for every pixel.
REQ-039 out_ready low for 3 cycles after row 0 -> res_ready=0 and row 0 held stable throughout; row 1 is accepted only after out_ready=1.
REQ-040 Reset at r=2 -> next cycle busy=0, out_valid=0, no done; a subsequent start completes normally. A start while busy is ignored.
